// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and state type
// for the input debounce/synchronizer stage.
package debounce_pkg;

  localparam int DEB_SYNC_STAGES   = 2;
  localparam int DEB_STABLE_CYCLES = 4;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: N-flop level synchronizer for one
// asynchronous input into the clk domain.
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [N-1:0] stages;

  // shift the raw level through the chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[N-2:0], async_in};
    end
  end

  assign sync_out = stages[N-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronize a raw level, filter it
// over a stable run and emit rise/fall strobes.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             q_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  deb_state_e       state;

  sync_chain #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(d_in),
    .sync_out(s)
  );

  assign state = (s != q) ? DEB_COUNTING : DEB_STABLE;
  assign busy  = (state == DEB_COUNTING);

  // filter decision: count disagreement, commit on run end
  always_comb begin
    cnt_nxt  = '0;
    q_nxt    = q;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    unique case (state)
      DEB_STABLE: begin
        cnt_nxt = '0;
      end
      DEB_COUNTING: begin
        if (cnt == CNT_LAST) begin
          q_nxt    = s;
          rise_nxt = s;
          fall_nxt = ~s;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

  // filter and strobe registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      q    <= q_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: default and fast (3-stage, 1-cycle)
// instances driven by one raw level, checked per edge.
module tb_debounce_sync;

  logic clk;
  logic reset;
  logic d_in;
  logic q0, rise0, fall0, busy0;
  logic q1, rise1, fall1, busy1;

  int checks;
  int errors;

  // reference: d_in samples (newest first), q, strobes,
  // and edge number of the last agreement per instance
  int   ss[2];
  int   sc[2];
  logic smp[8];
  logic qm[2];
  logic rm[2];
  logic fm[2];
  int   la[2];
  int   n;
  int   rc0, fc0, rc1, fc1;

  debounce_sync dut (
    .clk  (clk),
    .reset(reset),
    .d_in (d_in),
    .q    (q0),
    .rise (rise0),
    .fall (fall0),
    .busy (busy0)
  );

  debounce_sync #(
    .SYNC_STAGES  (3),
    .STABLE_CYCLES(1)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .d_in (d_in),
    .q    (q1),
    .rise (rise1),
    .fall (fall1),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d",
               tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) smp[k] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      qm[i] = 1'b0;
      rm[i] = 1'b0;
      fm[i] = 1'b0;
      la[i] = n;
    end
  endtask

  // q flips once s has disagreed with q on sc
  // consecutive edges since the last agreement
  task automatic model_edge();
    logic sp;
    n++;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      sp    = smp[ss[i]-1];
      rm[i] = 1'b0;
      fm[i] = 1'b0;
      if (sp == qm[i]) begin
        la[i] = n;
      end else if (n - la[i] == sc[i]) begin
        qm[i] = sp;
        rm[i] = sp;
        fm[i] = !sp;
        la[i] = n;
      end
    end
    for (int k = 7; k > 0; k--) smp[k] = smp[k-1];
    smp[0] = d_in;
  endtask

  task automatic compare();
    chk("q0",    q0,    qm[0]);
    chk("rise0", rise0, rm[0]);
    chk("fall0", fall0, fm[0]);
    chk("busy0", busy0, smp[ss[0]-1] != qm[0]);
    chk("q1",    q1,    qm[1]);
    chk("rise1", rise1, rm[1]);
    chk("fall1", fall1, fm[1]);
    chk("busy1", busy1, smp[ss[1]-1] != qm[1]);
    chk("excl0", rise0 & fall0, 0);
    chk("excl1", rise1 & fall1, 0);
  endtask

  // one edge: update model, check 1ns later,
  // return 3ns after the edge for mid-cycle drive
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (rise0) rc0++;
    if (fall0) fc0++;
    if (rise1) rc1++;
    if (fall1) fc1++;
    #2;
  endtask

  task automatic clr_cnt();
    rc0 = 0; fc0 = 0; rc1 = 0; fc1 = 0;
  endtask

  int lat0, lat1;

  initial begin
    checks = 0;
    errors = 0;
    n = 0;
    ss[0] = 2; sc[0] = 4;
    ss[1] = 3; sc[1] = 1;
    clr_cnt();
    model_reset();
    reset = 1'b1;
    d_in  = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    #2;
    chk("rst_q0",    q0,    0);
    chk("rst_rise0", rise0, 0);
    chk("rst_fall0", fall0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_q1",    q1,    0);
    chk("rst_busy1", busy1, 0);
    repeat (3) step();

    // release just after an edge, d_in held high
    reset = 1'b1;
    lat0 = -1;
    lat1 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (q0 && lat0 < 0) lat0 = k;
      if (q1 && lat1 < 0) lat1 = k;
    end
    chk("lat_rise0", lat0, 6);
    chk("lat_rise1", lat1, 4);

    // falling step from q = 1
    clr_cnt();
    d_in = 1'b0;
    lat0 = -1;
    lat1 = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (fall0 && lat0 < 0) lat0 = k;
      if (fall1 && lat1 < 0) lat1 = k;
    end
    chk("lat_fall0", lat0, 6);
    chk("lat_fall1", lat1, 4);
    chk("fall_rises0", rc0, 0);
    chk("fall_falls0", fc0, 1);

    // 3-cycle glitch rejected
    clr_cnt();
    d_in = 1'b1;
    repeat (3) step();
    d_in = 1'b0;
    repeat (12) step();
    chk("p3_rises0", rc0, 0);
    chk("p3_falls0", fc0, 0);

    // 4-cycle pulse passes
    clr_cnt();
    d_in = 1'b1;
    repeat (4) step();
    d_in = 1'b0;
    repeat (12) step();
    chk("p4_rises0", rc0, 1);
    chk("p4_falls0", fc0, 1);

    // bounce every 2 cycles, then hold high
    clr_cnt();
    for (int g = 0; g < 6; g++) begin
      d_in = (g % 2 == 0);
      repeat (2) step();
    end
    d_in = 1'b1;
    lat0 = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rise0 && lat0 < 0) lat0 = k;
    end
    chk("bnc_lat0",   lat0, 6);
    chk("bnc_rises0", rc0, 1);
    chk("bnc_falls0", fc0, 0);

    // reset in the middle of a count
    d_in = 1'b0;
    repeat (12) step();
    d_in = 1'b1;
    repeat (4) step();
    #2;
    chk("mid_cnt_pre", dut.cnt, 2);
    chk("mid_busy_pre", busy0, 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_q0",   q0,      0);
    chk("mid_busy", busy0,   0);
    chk("mid_cnt",  dut.cnt, 0);
    d_in = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    clr_cnt();
    repeat (20) step();
    chk("mid_strb0", rc0 + fc0, 0);
    chk("mid_strb1", rc1 + fc1, 0);
    chk("mid_busy_end", busy0, 0);

    // random level runs with occasional async reset
    for (int g = 0; g < 250; g++) begin
      d_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) step();
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst_q0", q0, 0);
        chk("rnd_rst_q1", q1, 0);
        step();
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
